// File: rtl/instr_encoder_if.sv
// Request and instruction-memory handshake bundle for instr_encoder.
// master is the encoder side, slave is the requester/memory side.
interface instr_encoder_if #(
    parameter int ADDR_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_kind;
    logic [4:0]        in_rs;
    logic [4:0]        in_rt;
    logic [4:0]        in_rd;
    logic [4:0]        in_shamt;
    logic [15:0]       in_imm;
    logic              imem_we;
    logic              imem_ready;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;

    modport master (
        input  in_valid, in_kind, in_rs, in_rt, in_rd,
        input  in_shamt, in_imm, imem_ready,
        output in_ready, imem_we, imem_addr, imem_wdata
    );

    modport slave (
        output in_valid, in_kind, in_rs, in_rt, in_rd,
        output in_shamt, in_imm, imem_ready,
        input  in_ready, imem_we, imem_addr, imem_wdata
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes MIPS mnemonic requests into instruction words and streams
// them into instruction memory from a base address, one word per write.
module instr_encoder #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              flush,
    instr_encoder_if.master   bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   words_written
);

    localparam logic [5:0] F_ADD  = 6'h20, F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22, F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24, F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27, F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLL  = 6'h00, F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03, F_JR   = 6'h08;
    localparam logic [5:0] OP_ADDI  = 6'h08, OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0C, OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05, OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25, OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23, OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_SB    = 6'h28, OP_SH    = 6'h29;

    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   CNT_ONE  = 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic              flush_pending;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;

    logic        legal, itype;
    logic [4:0]  rs_f, rt_f, rd_f, sh_f;
    logic [5:0]  op, func;
    logic [31:0] word;
    logic        complete, last_addr_held, in_ready, accept;

    always_comb begin
        legal = 1'b1;
        itype = 1'b0;
        rs_f  = bus.in_rs;
        rt_f  = bus.in_rt;
        rd_f  = bus.in_rd;
        sh_f  = 5'd0;
        op    = 6'd0;
        func  = 6'd0;
        unique case (bus.in_kind)
            5'd0:  func = F_ADD;
            5'd1:  func = F_ADDU;
            5'd2:  func = F_SUB;
            5'd3:  func = F_SUBU;
            5'd4:  func = F_AND;
            5'd5:  func = F_OR;
            5'd6:  func = F_NOR;
            5'd7:  begin rs_f = 5'd0; sh_f = bus.in_shamt; func = F_SLL; end
            5'd8:  begin rs_f = 5'd0; sh_f = bus.in_shamt; func = F_SRL; end
            5'd9:  begin rs_f = 5'd0; sh_f = bus.in_shamt; func = F_SRA; end
            5'd10: func = F_SLT;
            5'd11: begin rt_f = 5'd0; rd_f = 5'd0; func = F_JR; end
            5'd12: begin itype = 1'b1; op = OP_ADDI;  end
            5'd13: begin itype = 1'b1; op = OP_ADDIU; end
            5'd14: begin itype = 1'b1; op = OP_ANDI;  end
            5'd15: begin itype = 1'b1; op = OP_BEQ;   end
            5'd16: begin itype = 1'b1; op = OP_BNE;   end
            5'd17: begin itype = 1'b1; op = OP_LBU;   end
            5'd18: begin itype = 1'b1; op = OP_LHU;   end
            5'd19: begin itype = 1'b1; op = OP_LUI; rs_f = 5'd0; end
            5'd20: begin itype = 1'b1; op = OP_LW;    end
            5'd21: begin itype = 1'b1; op = OP_ORI;   end
            5'd22: begin itype = 1'b1; op = OP_SLTI;  end
            5'd23: begin itype = 1'b1; op = OP_SLTIU; end
            5'd24: begin itype = 1'b1; op = OP_SB;    end
            5'd25: begin itype = 1'b1; op = OP_SH;    end
            default: legal = 1'b0;
        endcase
        word = itype ? {op, rs_f, rt_f, bus.in_imm}
                     : {6'd0, rs_f, rt_f, rd_f, sh_f, func};
    end

    assign complete       = we_q && bus.imem_ready;
    assign last_addr_held = we_q && (addr_q == '1);
    assign in_ready = (state == RUN) && !flush_pending &&
                      (!we_q || bus.imem_ready) && !last_addr_held;
    assign accept   = bus.in_valid && in_ready;

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            addr          <= '0;
            flush_pending <= 1'b0;
            we_q          <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            err           <= 1'b0;
            words_written <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state         <= RUN;
                        addr          <= base_addr;
                        words_written <= '0;
                        flush_pending <= 1'b0;
                    end
                end
                RUN: begin
                    if (flush) flush_pending <= 1'b1;
                    if (complete) words_written <= words_written + CNT_ONE;
                    // addr tracks the next word to assign; it saturates at all-ones
                    if (accept && legal) begin
                        we_q    <= 1'b1;
                        addr_q  <= addr;
                        wdata_q <= word;
                        if (addr != '1) addr <= addr + ADDR_ONE;
                    end else if (complete) begin
                        we_q <= 1'b0;
                    end
                    if (accept && !legal) err <= 1'b1;
                    if (complete && last_addr_held) begin
                        state <= DONE;
                    end else if (flush_pending && (!we_q || complete)) begin
                        state         <= IDLE;
                        flush_pending <= 1'b0;
                    end
                end
                DONE: begin
                    if (flush) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder.
// Vectors carry hand-encoded MIPS words.
module tb_instr_encoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] base_addr;
    logic       flush;
    logic       busy, done, err;
    logic [8:0] words_written;

    int checks = 0;
    int errors = 0;

    instr_encoder_if #(.ADDR_W(8)) bus ();

    instr_encoder #(.ADDR_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .base_addr    (base_addr),
        .flush        (flush),
        .bus          (bus.master),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_written(words_written)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [4:0] kind, input logic [4:0] rs,
                       input logic [4:0] rt, input logic [4:0] rd,
                       input logic [4:0] sh, input logic [15:0] imm);
        bus.in_valid = 1'b1;
        bus.in_kind  = kind;
        bus.in_rs    = rs;
        bus.in_rt    = rt;
        bus.in_rd    = rd;
        bus.in_shamt = sh;
        bus.in_imm   = imm;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = 8'h00;
        flush = 1'b0;
        bus.imem_ready = 1'b0;
        req(5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0);
        bus.in_valid = 1'b0;
        #12;
        check("rst_we", 32'(bus.imem_we), 32'd0);
        check("rst_addr", 32'(bus.imem_addr), 32'd0);
        check("rst_wdata", bus.imem_wdata, 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd0);
        check("rst_flags", {29'd0, busy, done, err}, 32'd0);
        check("rst_cnt", 32'(words_written), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // session at 0x10, memory always ready
        base_addr = 8'h10;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("run_busy", 32'(busy), 32'd1);
        bus.imem_ready = 1'b1;
        req(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        #1 check("add_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("add_we", 32'(bus.imem_we), 32'd1);
        check("add_addr", 32'(bus.imem_addr), 32'h10);
        check("add_wdata", bus.imem_wdata, 32'h00221820);
        req(5'd12, 5'd0, 5'd5, 5'd0, 5'd0, 16'hFFFF);
        tick();
        check("add_cnt", 32'(words_written), 32'd1);
        check("addi_addr", 32'(bus.imem_addr), 32'h11);
        check("addi_wdata", bus.imem_wdata, 32'h2005FFFF);
        req(5'd19, 5'd7, 5'd4, 5'd0, 5'd0, 16'h1234);
        tick();
        check("lui_addr", 32'(bus.imem_addr), 32'h12);
        check("lui_wdata", bus.imem_wdata, 32'h3C041234);
        req(5'd7, 5'd9, 5'd1, 5'd2, 5'd4, 16'h0);
        tick();
        check("sll_addr", 32'(bus.imem_addr), 32'h13);
        check("sll_wdata", bus.imem_wdata, 32'h00011100);
        bus.in_valid = 1'b0;
        tick();
        check("burst_cnt", 32'(words_written), 32'd4);
        check("burst_we", 32'(bus.imem_we), 32'd0);

        // memory stalls for 3 cycles with a second request waiting
        bus.imem_ready = 1'b0;
        req(5'd5, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0);
        tick();
        check("or_addr", 32'(bus.imem_addr), 32'h14);
        req(5'd2, 5'd4, 5'd5, 5'd6, 5'd0, 16'h0);
        for (int i = 0; i < 3; i++) begin
            #1 check("stall_ready", 32'(bus.in_ready), 32'd0);
            tick();
            check("stall_we", 32'(bus.imem_we), 32'd1);
            check("stall_addr", 32'(bus.imem_addr), 32'h14);
            check("stall_wdata", bus.imem_wdata, 32'h00221825);
        end
        bus.imem_ready = 1'b1;
        #1 check("unstall_ready", 32'(bus.in_ready), 32'd1);
        tick();
        check("sub_addr", 32'(bus.imem_addr), 32'h15);
        check("sub_wdata", bus.imem_wdata, 32'h00853022);
        check("stall_cnt", 32'(words_written), 32'd5);
        bus.in_valid = 1'b0;
        tick();
        check("stall_cnt2", 32'(words_written), 32'd6);

        // illegal mnemonic is swallowed
        req(5'd27, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0);
        tick();
        check("ill_we", 32'(bus.imem_we), 32'd0);
        check("ill_err", 32'(err), 32'd1);
        req(5'd4, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0);
        tick();
        check("and_addr", 32'(bus.imem_addr), 32'h16);
        check("and_wdata", bus.imem_wdata, 32'h00210824);
        check("err_sticky", 32'(err), 32'd1);
        bus.in_valid = 1'b0;
        tick();
        check("ill_cnt", 32'(words_written), 32'd7);

        // flush with a held word
        bus.imem_ready = 1'b0;
        req(5'd21, 5'd2, 5'd3, 5'd0, 5'd0, 16'h00AA);
        tick();
        check("ori_addr", 32'(bus.imem_addr), 32'h17);
        check("ori_wdata", bus.imem_wdata, 32'h344300AA);
        bus.in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b1;
        #1 check("fl_ready", 32'(bus.in_ready), 32'd0);
        check("fl_held", {30'd0, bus.imem_we, busy}, 32'd3);
        tick();
        check("fl_held2", 32'(bus.imem_we), 32'd1);
        bus.imem_ready = 1'b1;
        tick();
        check("fl_idle", {30'd0, bus.imem_we, busy}, 32'd0);
        check("fl_cnt", 32'(words_written), 32'd8);
        check("idle_ready", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;

        // top of address space
        base_addr = 8'hFE;
        start = 1'b1;
        tick();
        start = 1'b0;
        req(5'd15, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0003);
        tick();
        check("top_addr0", 32'(bus.imem_addr), 32'hFE);
        check("beq_wdata", bus.imem_wdata, 32'h10220003);
        tick();
        check("top_addr1", 32'(bus.imem_addr), 32'hFF);
        #1 check("top_ready", 32'(bus.in_ready), 32'd0);
        tick();
        check("top_done", {29'd0, bus.imem_we, busy, done}, 32'd1);
        check("top_cnt", 32'(words_written), 32'd2);
        tick();
        check("top_nowrite", 32'(bus.imem_we), 32'd0);
        check("top_ready2", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("done_flush", {30'd0, busy, done}, 32'd0);

        // reset in the middle of a held word
        base_addr = 8'h20;
        start = 1'b1;
        tick();
        start = 1'b0;
        bus.imem_ready = 1'b0;
        req(5'd20, 5'd1, 5'd2, 5'd0, 5'd0, 16'h0004);
        tick();
        check("lw_we", 32'(bus.imem_we), 32'd1);
        check("lw_wdata", bus.imem_wdata, 32'h8C220004);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_we", 32'(bus.imem_we), 32'd0);
        check("mrst_addr", 32'(bus.imem_addr), 32'd0);
        check("mrst_wdata", bus.imem_wdata, 32'd0);
        check("mrst_flags", {29'd0, busy, done, err}, 32'd0);
        check("mrst_cnt", 32'(words_written), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("post_idle", {29'd0, bus.in_ready, bus.imem_we, busy}, 32'd0);
        bus.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory word-address width.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  one-cycle pulse that begins a load session from base_addr.
REQ-005 base_addr  input  ADDR_W  first word address of the session.
REQ-006 flush  input  1  ends the session after any held output word drains.
REQ-007 in_valid / in_ready  input / output  1 / 1  instruction-request handshake.
REQ-008 in_kind  input  5  mnemonic code: 0 ADD, 1 ADDU, 2 SUB, 3 SUBU, 4 AND, 5 OR, 6 NOR, 7 SLL, 8 SRL, 9 SRA, 10 SLT, 11 JR, 12 ADDI, 13 ADDIU, 14 ANDI, 15 BEQ, 16 BNE, 17 LBU, 18 LHU, 19 LUI, 20 LW, 21 ORI, 22 SLTI, 23 SLTIU, 24 SB, 25 SH; 26-31 illegal.
REQ-009 in_rs, in_rt, in_rd, in_shamt  input  5 each  register and shift-amount fields.
REQ-010 in_imm  input  16  immediate field.
REQ-011 imem_we / imem_ready  output / input  1 / 1  memory-write handshake.
REQ-012 imem_addr  output  ADDR_W  word address of the write.
REQ-013 imem_wdata  output  32  encoded instruction word.
REQ-014 busy  output  1  high in RUN.
REQ-015 done  output  1  high in DONE.
REQ-016 err  output  1  sticky illegal-mnemonic flag.
REQ-017 words_written  output  ADDR_W+1  count of completed memory writes this session.

Function
REQ-018 Opcode and function values SHALL come from controller_constants.vh and be standard MIPS: func ADD 0x20, ADDU 0x21, SUB 0x22, SUBU 0x23, AND 0x24, OR 0x25, NOR 0x27, SLT 0x2A, SLL 0x00, SRL 0x02, SRA 0x03, JR 0x08; opcode ADDI 0x08, ADDIU 0x09, ANDI 0x0C, BEQ 0x04, BNE 0x05, LBU 0x24, LHU 0x25, LUI 0x0F, LW 0x23, ORI 0x0D, SLTI 0x0A, SLTIU 0x0B, SB 0x28, SH 0x29.
REQ-019 R-type words SHALL be {6'b0, rs, rt, rd, shamt, func}.
  - SLL/SRL/SRA: rs forced to 0.
  - JR: rt, rd and shamt forced to 0.
  - Other R-type: shamt forced to 0.
REQ-020 I-type words SHALL be {opcode, rs, rt, imm}; LUI forces rs to 0; imm passes through unmodified.
REQ-021 States SHALL be IDLE, RUN and DONE.
  - IDLE -> RUN on start: addr <= base_addr, words_written <= 0, err is not cleared.
  - RUN -> DONE after the write to address all-ones completes; addr never wraps.
  - RUN -> IDLE on flush once no word is held; flush in DONE -> IDLE.
  - start outside IDLE is ignored.
REQ-022 in_ready SHALL equal RUN && !flush_pending && (!imem_we || imem_ready) && !last_addr_held.
  - last_addr_held: a word for address all-ones is held.
REQ-023 An accepted legal request SHALL appear on imem_we/imem_wdata/imem_addr the next cycle.
  - Latency is 1 cycle.
  - Output is held stable until imem_ready.
  - A new request may be accepted in the cycle the held word completes, giving full throughput.
REQ-024 A write SHALL complete on imem_we && imem_ready; addr and words_written then increment by 1.
REQ-025 An accepted illegal in_kind SHALL be consumed without any write, SHALL set err, and SHALL leave addr unchanged.
REQ-026 flush SHALL be latched as flush_pending.
  - in_ready drops from the next cycle.
  - A held word still completes before the transition to IDLE.

Reset
REQ-027 While rst_n is low, the block SHALL force IDLE and drive imem_we=0, imem_addr=0, imem_wdata=0, in_ready=0, busy=0, done=0, err=0, words_written=0, flush_pending=0.
REQ-028 Reset asserted mid-session SHALL discard any held word with no partial write; after release the block SHALL wait in IDLE for start.

Verification
REQ-029 start with base_addr=0x10, then ADD rs=1 rt=2 rd=3, imem_ready=1 -> cycle+1: imem_we=1, addr=0x10, wdata=0x00221820; words_written=1.
REQ-030 ADDI rs=0 rt=5 imm=0xFFFF -> wdata=0x2005FFFF; LUI rs=7 rt=4 imm=0x1234 -> wdata=0x3C041234; SLL rs=9 rt=1 rd=2 shamt=4 -> wdata=0x00011100.
REQ-031 Back-to-back legal requests with imem_ready held low for 3 cycles -> wdata/addr stable, in_ready=0, no request lost; addresses 0x10, 0x11, 0x12 written in order.
REQ-032 in_kind=27 accepted -> no imem_we, err=1 stays set, addr unchanged; next legal request writes the unchanged address.
REQ-033 base_addr=0xFE with ADDR_W=8 and three requests -> writes 0xFE and 0xFF, then done=1 and in_ready=0; third request never accepted.
REQ-034 flush while a word is held with imem_ready low -> word completes when imem_ready rises, then IDLE; rst_n low mid-hold -> imem_we=0 immediately and all outputs at reset values.
